// File: rtl/asi_w_if.sv
// asi_w_if: AXI4 write channels (AW/W/B) plus the user-side write port
// of the asi_w responder.
//   slave  modport : used by asi_w. It receives AW/W/BREADY and usr_wready/usr_werr,
//                    and drives AWREADY/WREADY/B and usr_we/usr_waddr/usr_wdata/usr_wstrb.
//   master modport : the complementary view, for the AXI master together with the
//                    user target.
interface asi_w_if #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_WSTRBW = AXI_DW / 8
) ();
  logic [AXI_IW-1:0]     AWID;
  logic [AXI_AW-1:0]     AWADDR;
  logic [AXI_LW-1:0]     AWLEN;
  logic [AXI_SW-1:0]     AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [AXI_DW-1:0]     WDATA;
  logic [AXI_WSTRBW-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [AXI_IW-1:0]     BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic                  usr_we;
  logic [AXI_AW-1:0]     usr_waddr;
  logic [AXI_DW-1:0]     usr_wdata;
  logic [AXI_WSTRBW-1:0] usr_wstrb;
  logic                  usr_wready;
  logic                  usr_werr;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID, BREADY, usr_wready, usr_werr,
    output AWREADY, WREADY, BID, BRESP, BVALID,
    output usr_we, usr_waddr, usr_wdata, usr_wstrb
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID, BREADY, usr_wready, usr_werr,
    input  AWREADY, WREADY, BID, BRESP, BVALID,
    input  usr_we, usr_waddr, usr_wdata, usr_wstrb
  );
endinterface

// File: rtl/asi_w.sv
// asi_w: AXI4 slave write-side responder. It accepts one AW burst at a time,
// turns each W beat into an addressed user write, and returns a single B
// response per burst.
//   ACLK   : clock
//   ARESET : synchronous active-high reset; every output is 0 while it is high
//   bus    : asi_w_if.slave (AW/W/B channels and the usr_* write port)
// Optional feature macro: ASI_W_WRAP_EN. When it is defined, WRAP bursts are
// supported. When it is undefined, every WRAP burst is drained and answered
// with SLVERR.
module asi_w #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_WSTRBW = AXI_DW / 8
) (
  input logic   ACLK,
  input logic   ARESET,
  asi_w_if.slave bus
);

  localparam logic [AXI_SW-1:0] SZ_MAX = AXI_SW'($clog2(AXI_WSTRBW));

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [AXI_IW-1:0] id_q, id_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [AXI_LW-1:0] len_q, len_d;
  logic [AXI_LW-1:0] cnt_q, cnt_d;
  logic [AXI_SW-1:0] size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              err_q, err_d;   // any error in the burst, reported as SLVERR
  logic              ill_q, ill_d;   // illegal burst: drain beats without writing

  logic              aw_illegal, aw_rdy, w_rdy, usr_we, w_hs, last_beat;
  logic [AXI_AW-1:0] bytes, aligned, incr_addr, next_addr;

  always_comb begin
    aw_illegal = (bus.AWBURST == 2'b11) || (bus.AWSIZE > SZ_MAX);
`ifdef ASI_W_WRAP_EN
    if ((bus.AWBURST == 2'b10) &&
        !((bus.AWLEN == AXI_LW'(1)) || (bus.AWLEN == AXI_LW'(3)) ||
          (bus.AWLEN == AXI_LW'(7)) || (bus.AWLEN == AXI_LW'(15))))
      aw_illegal = 1'b1;
`else
    if (bus.AWBURST == 2'b10)
      aw_illegal = 1'b1;
`endif
  end

`ifdef ASI_W_WRAP_EN
  logic [AXI_AW-1:0] wrap_total, wrap_base, wrap_addr;

  // The wrap window is the whole burst (bytes * beats). This is always a
  // power of two because the beat count is limited to 2, 4, 8 or 16.
  always_comb begin
    wrap_total = bytes * (AXI_AW'(len_q) + AXI_AW'(1));
    wrap_base  = addr_q & ~(wrap_total - AXI_AW'(1));
    wrap_addr  = (incr_addr == wrap_base + wrap_total) ? wrap_base : incr_addr;
  end
`endif

  // Beat address advance. Only the first beat can be unaligned. Every later
  // beat is aligned to the beat size.
  always_comb begin
    bytes     = AXI_AW'(1) << size_q;
    aligned   = (addr_q >> size_q) << size_q;
    incr_addr = aligned + bytes;
    case (burst_q)
      2'b01:   next_addr = incr_addr;
`ifdef ASI_W_WRAP_EN
      2'b10:   next_addr = wrap_addr;
`endif
      default: next_addr = addr_q;
    endcase
  end

  assign aw_rdy    = (state_q == IDLE) && !ARESET;
  assign w_rdy     = (state_q == DATA) && !ARESET && (ill_q || bus.usr_wready);
  assign usr_we    = (state_q == DATA) && !ARESET && !ill_q && bus.WVALID;
  assign w_hs      = bus.WVALID && w_rdy;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (bus.AWVALID && aw_rdy) begin
          id_d    = bus.AWID;
          addr_d  = bus.AWADDR;
          len_d   = bus.AWLEN;
          size_d  = bus.AWSIZE;
          burst_d = bus.AWBURST;
          cnt_d   = '0;
          err_d   = aw_illegal;
          ill_d   = aw_illegal;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          cnt_d  = cnt_q + AXI_LW'(1);
          addr_d = next_addr;
          if (usr_we && bus.usr_werr)
            err_d = 1'b1;
          // A misplaced WLAST is only flagged. The beat counter alone ends the burst.
          if (bus.WLAST != last_beat)
            err_d = 1'b1;
          if (last_beat)
            state_d = RESP;
        end
      end
      RESP: begin
        if (bus.BREADY)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
    end
    id_q    <= id_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    size_q  <= size_d;
    burst_q <= burst_d;
  end

  assign bus.AWREADY   = aw_rdy;
  assign bus.WREADY    = w_rdy;
  assign bus.BVALID    = (state_q == RESP) && !ARESET;
  assign bus.BID       = ((state_q == RESP) && !ARESET) ? id_q : '0;
  assign bus.BRESP     = ((state_q == RESP) && !ARESET && err_q) ? 2'b10 : 2'b00;
  assign bus.usr_we    = usr_we;
  assign bus.usr_waddr = ((state_q == DATA) && !ARESET) ? addr_q : '0;
  assign bus.usr_wdata = ARESET ? '0 : bus.WDATA;
  assign bus.usr_wstrb = ARESET ? '0 : bus.WSTRB;

endmodule

// File: tb/tb_asi_w.sv
// tb_asi_w: a randomized and directed bench for asi_w. Expected beat
// addresses and responses come from a burst-level model built on plain
// modulo arithmetic.
module tb_asi_w;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0]  got_a[$];
  logic [127:0] got_d[$];

  asi_w_if bus ();
  asi_w dut (.ACLK(clk), .ARESET(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wrap_ok(input logic [7:0] len);
`ifdef ASI_W_WRAP_EN
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
`else
    return 1'b0;
`endif
  endfunction

  // Address of beat i, worked out directly from the burst description.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] bt,
                                             input int i);
    logic [31:0] bytes, al, total, base;
    bytes = 32'd1 << size;
    al    = a - (a % bytes);
    if (i == 0 || bt == 2'b00) return a;
    if (bt == 2'b01) return al + 32'(i) * bytes;
    total = bytes * (32'(len) + 32'd1);
    base  = a - (a % total);
    return base + ((al - base + 32'(i) * bytes) % total);
  endfunction

  task automatic recover();
    @(negedge clk);
    rst = 1'b1; bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input int wl_beat,
                           input int werr_beat, input int bp_after, input int bp_cycles,
                           input bit rnd_rdy, input int bstall);
    bit           legal, exp_err, acc;
    logic [31:0]  ea[$];
    logic [127:0] ed[$];
    logic [127:0] wd;
    int           beat, stall, cyc, lowcnt, n;
    legal = (bt != 2'b11) && (size <= 3'd4);
    if (bt == 2'b10) legal = legal && wrap_ok(len);
    exp_err = !legal || (wl_beat != int'(len)) ||
              (werr_beat >= 0 && werr_beat <= int'(len));
    for (int i = 0; i <= int'(len); i++) ea.push_back(model_addr(addr, len, size, bt, i));
    got_a.delete(); got_d.delete();

    @(negedge clk);
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
    bus.AWBURST = bt; bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.usr_wready = 1'b1;
    #1;
    chk("w_before_aw", 128'(bus.WREADY), 128'(0));
    cyc = 0;
    while (!bus.AWREADY && cyc < 50) begin @(negedge clk); #1; cyc++; end
    if (!bus.AWREADY) begin chk("aw_timeout", 128'(0), 128'(1)); recover(); return; end
    @(negedge clk);
    bus.AWVALID = 1'b0;

    beat = 0; stall = 0; cyc = 0; lowcnt = 0;
    while (beat <= int'(len) && cyc < 400) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      bus.WDATA = wd; bus.WSTRB = 16'($urandom);
      bus.WLAST = (beat == wl_beat); bus.usr_werr = (beat == werr_beat);
      bus.usr_wready = (stall > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      if (legal) begin
        if (!bus.WREADY) lowcnt++;
        chk("wready_follow", 128'(bus.WREADY), 128'(bus.usr_wready));
      end else begin
        chk("drain_wready", 128'(bus.WREADY), 128'(1));
        chk("drain_we", 128'(bus.usr_we), 128'(0));
      end
      if (bus.usr_we && bus.usr_wready) begin
        got_a.push_back(bus.usr_waddr);
        got_d.push_back(bus.usr_wdata);
      end
      acc = bus.WREADY;
      if (acc) ed.push_back(wd);
      @(posedge clk);
      if (stall > 0) stall--;
      if (acc) begin
        if (beat == bp_after) stall = bp_cycles;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.usr_werr = 1'b0; bus.usr_wready = 1'b1;
    if (beat <= int'(len)) begin chk("w_timeout", 128'(beat), 128'(len) + 1); recover(); return; end
    #1;
    chk("bvalid_rise", 128'(bus.BVALID), 128'(1));
    if (!rnd_rdy && bp_cycles > 0) chk("bp_low_cycles", 128'(lowcnt), 128'(bp_cycles));
    chk("bid", 128'(bus.BID), 128'(id));
    chk("bresp", 128'(bus.BRESP), exp_err ? 128'(2) : 128'(0));
    for (int k = 0; k < bstall; k++) begin
      @(negedge clk); #1;
      chk("bvalid_hold", 128'(bus.BVALID), 128'(1));
      chk("bid_hold", 128'(bus.BID), 128'(id));
      chk("bresp_hold", 128'(bus.BRESP), exp_err ? 128'(2) : 128'(0));
      chk("awready_in_resp", 128'(bus.AWREADY), 128'(0));
    end
    @(negedge clk);
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    #1;
    chk("b_done", 128'(bus.BVALID), 128'(0));
    chk("aw_after_b", 128'(bus.AWREADY), 128'(1));

    chk("nwrites", 128'(got_a.size()), legal ? 128'(len) + 1 : 128'(0));
    n = (got_a.size() < ea.size()) ? got_a.size() : ea.size();
    if (legal)
      for (int i = 0; i < n; i++) begin
        chk($sformatf("waddr[%0d]", i), 128'(got_a[i]), 128'(ea[i]));
        chk($sformatf("wdata[%0d]", i), got_d[i], ed[i]);
      end
  endtask

  initial begin
    logic [1:0] bt;
    logic [2:0] sz;
    logic [7:0] ln;
    int         wl, we, r;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.usr_wready = 1'b1; bus.usr_werr = 1'b0;

    // While reset is held, every output must read 0, even with activity on the inputs.
    repeat (2) @(negedge clk);
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.WDATA = {4{32'hA5A5_5A5A}}; bus.BREADY = 1'b1;
    #1;
    chk("rst_awready", 128'(bus.AWREADY), 128'(0));
    chk("rst_wready", 128'(bus.WREADY), 128'(0));
    chk("rst_bvalid", 128'(bus.BVALID), 128'(0));
    chk("rst_usr_we", 128'(bus.usr_we), 128'(0));
    chk("rst_usr_wdata", bus.usr_wdata, 128'(0));
    @(negedge clk);
    rst = 1'b0; bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    #1;
    chk("post_rst_awready", 128'(bus.AWREADY), 128'(1));

    // Directed scenarios: plain INCR, unaligned INCR, WRAP, backpressure,
    // WLAST error, user error, and B stall.
    run_burst(8'h5A, 32'h1000, 8'd3, 3'd4, 2'b01, 3, -1, -1, 0, 1'b0, 0);
    run_burst(8'h11, 32'h1004, 8'd1, 3'd4, 2'b01, 1, -1, -1, 0, 1'b0, 0);
    run_burst(8'h22, 32'h1030, 8'd3, 3'd4, 2'b10, 3, -1, -1, 0, 1'b0, 0);
    run_burst(8'h33, 32'h2000, 8'd3, 3'd4, 2'b01, 3, -1, 0, 3, 1'b0, 0);
    run_burst(8'h44, 32'h3000, 8'd3, 3'd4, 2'b01, 0, -1, -1, 0, 1'b0, 0);
    run_burst(8'h55, 32'h4000, 8'd3, 3'd4, 2'b01, 3, 1, -1, 0, 1'b0, 0);
    run_burst(8'h66, 32'h5000, 8'd2, 3'd2, 2'b00, 2, -1, -1, 0, 1'b0, 5);
    run_burst(8'h77, 32'h6000, 8'd1, 3'd5, 2'b01, 1, -1, -1, 0, 1'b0, 0);
    run_burst(8'h88, 32'h7000, 8'd1, 3'd2, 2'b11, 1, -1, -1, 0, 1'b0, 0);

    // Reset during a burst: the burst is dropped and no B is issued.
    @(negedge clk);
    bus.AWID = 8'h99; bus.AWADDR = 32'h8000; bus.AWLEN = 8'd3; bus.AWSIZE = 3'd4;
    bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
    #1;
    chk("mid_rst_aw", 128'(bus.AWREADY), 128'(1));
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b1; bus.usr_wready = 1'b1; bus.WLAST = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("mid_rst_wready", 128'(bus.WREADY), 128'(1));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_awready", 128'(bus.AWREADY), 128'(0));
    chk("mid_rst_wready0", 128'(bus.WREADY), 128'(0));
    chk("mid_rst_usr_we", 128'(bus.usr_we), 128'(0));
    chk("mid_rst_waddr", 128'(bus.usr_waddr), 128'(0));
    chk("mid_rst_bvalid", 128'(bus.BVALID), 128'(0));
    @(negedge clk);
    rst = 1'b0; bus.WVALID = 1'b0;
    #1;
    chk("mid_rst_aw_next", 128'(bus.AWREADY), 128'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("mid_rst_no_b", 128'(bus.BVALID), 128'(0));
    end

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      bt = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
      sz = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
      if (bt == 2'b10 && $urandom_range(0, 4) != 0) begin
        r  = $urandom_range(0, 3);
        ln = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : 8'd15;
      end else begin
        ln = 8'($urandom_range(0, 15));
      end
      wl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(ln)) : int'(ln);
      we = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(ln)) : -1;
      run_burst(8'($urandom), $urandom, ln, sz, bt, wl, we, -1, 0, 1'b1, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/asi_w.md
Name: asi_w

Overview:
- AXI4 slave write-side responder. It is the counterpart of the team's AXI master interface.
- Accepts AW/W bursts from an AXI master and converts each beat into an addressed user write (address, data, strobe).
- Returns one B response per burst.
- Single clock domain. One burst in flight at a time. Sits in front of on-chip RAM or register targets.

Parameters:
- AXI_DW, 128, AXI data bus width (power of 2, >=8)
- AXI_AW, 32, AXI address width
- AXI_IW, 8, ID width
- AXI_LW, 8, AWLEN width
- AXI_SW, 3, AWSIZE width
- AXI_WSTRBW, AXI_DW/8, strobe width (derived)

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset, synchronous, active-high
- AWID  in  AXI_IW  write ID
- AWADDR  in  AXI_AW  burst start address
- AWLEN  in  AXI_LW  beats-1
- AWSIZE  in  AXI_SW  log2 bytes/beat
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1  / AWREADY  out  1  AW handshake
- WDATA  in  AXI_DW / WSTRB  in  AXI_WSTRBW / WLAST  in  1  write data
- WVALID  in  1  / WREADY  out  1  W handshake
- BID  out  AXI_IW / BRESP  out  2  response
- BVALID  out  1  / BREADY  in  1  B handshake
- usr_we  out  1  user write strobe (one beat)
- usr_waddr  out  AXI_AW  beat address
- usr_wdata  out  AXI_DW / usr_wstrb  out  AXI_WSTRBW  beat payload (pass-through of WDATA/WSTRB)
- usr_wready  in  1  user can accept a write this cycle
- usr_werr  in  1  user error for the beat where usr_we & usr_wready

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, DATA, RESP. Reset state is IDLE.
- All outputs are 0 while ARESET is high.
- AWREADY = (state==IDLE) & !ARESET. A W beat arriving before AW waits, because WREADY=0 outside DATA.
- IDLE: on AWVALID&AWREADY, latch id, addr, len, size, burst; clear beat counter and error flag; go to DATA. First W beat is accepted no earlier than the next cycle.
- Burst legality is checked at AW accept. Illegal bursts are:
  - AWBURST==11;
  - AWSIZE > log2(AXI_WSTRBW);
  - WRAP with len not in {1,3,7,15}.
- Illegal burst handling: set error flag; beats are still consumed with WREADY=1 and usr_we=0.
- DATA, legal burst: WREADY=usr_wready; usr_we=WVALID; usr_waddr=current address. usr_wdata/usr_wstrb are combinational from WDATA/WSTRB.
- Beat accepted on WVALID&WREADY:
  - counter increments;
  - address advances;
  - usr_werr ORs into the error flag.
- WLAST check: a beat with WLAST != (counter==len) sets the error flag. Termination follows the counter only. The beat with counter==len moves the FSM to RESP; extra or early WLAST does not change the beat count.
- Address arithmetic, with bytes=1<<size:
  - FIXED: address unchanged.
  - INCR: next = ((addr>>size)<<size) + bytes, modulo 2^AXI_AW. The first beat uses the unaligned start address.
  - WRAP: total = bytes*(len+1); base = addr & ~(total-1). If next equals base+total, next = base.
- RESP: BVALID=1, BID=latched id, BRESP=10 (SLVERR) if the error flag is set, else 00. BID/BRESP are held stable until BREADY; then return to IDLE.
- BVALID rises the cycle after the last W handshake.
- A new AW is accepted no earlier than the cycle after the B handshake.
- Reset mid-burst: return to IDLE immediately; the burst is dropped and no B is issued.

Optional Feature:
- Macro: ASI_W_WRAP_EN.
- Defined: WRAP bursts are supported as described above.
- Undefined: every WRAP burst is illegal. Beats are drained with usr_we=0 and BRESP=10. The wrap-boundary logic is not compiled.

Test Plan:
- INCR: AWADDR=0x1000, AWLEN=3, AWSIZE=4, AWID=0x5A, usr_wready=1 -> usr_waddr 0x1000, 0x1010, 0x1020, 0x1030 on 4 consecutive usr_we. Then BVALID with BID=0x5A, BRESP=00.
- Unaligned INCR: AWADDR=0x1004, AWLEN=1, AWSIZE=4 -> usr_waddr 0x1004 then 0x1010; BRESP=00.
- WRAP: AWADDR=0x1030, AWLEN=3, AWSIZE=4:
  - with ASI_W_WRAP_EN -> usr_waddr 0x1030, 0x1000, 0x1010, 0x1020; BRESP=00;
  - without -> 4 beats consumed, usr_we never high, BRESP=10.
- Backpressure: usr_wready low for 3 cycles after beat 1 of a 4-beat INCR -> WREADY low for those 3 cycles; all 4 beats are written exactly once, in order; BRESP=00.
- Protocol error: WLAST asserted on beat 1 of an AWLEN=3 burst; usr_werr=1 on beat 2 of another burst -> each burst still consumes 4 beats, and each returns BRESP=10.
- B stall and reset:
  - BREADY low for 5 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout; AW accepted the cycle after the B handshake.
  - ARESET pulsed after beat 2 -> outputs 0 during reset, AWREADY=1 next cycle, no B issued.
